timer_sequencer: RTL
====================

// Module: timer_sequencer
// PURPOSE
//  Avalon-MM master that programs and services the avalon_timer slave. On start it writes
//  end-of-count, threshold and enable. On each timer irq it reads the live count, pulses
//  borra_irq and counts periods. After N periods, or on stop, it disables the timer.
//  Sits between the CPU-side control logic and the timer slave port.
// PARAMETERS
//  RD_LAT    1   cycles from tmr_read to valid tmr_readdata (fixed-latency slave, no waitrequest)
//  IRQ_GUARD 2   cycles irq is ignored after an acknowledge (covers registered irq clear)
//  PW        16  width of period counters
// PORTS
//  clock            in   1   system clock
//  reset            in   1   synchronous, active-high reset
//  start            in   1   1-cycle pulse: begin a sequence (ignored while busy)
//  stop             in   1   1-cycle pulse: abort the running sequence
//  cfg_period       in   32  end-of-count value, written to timer reg0
//  cfg_threshold    in   32  threshold value, written to timer reg1
//  cfg_num_periods  in   PW  periods before auto-stop; 0 = free-run until stop
//  timer_irq        in   1   irq from timer, level, held until borra_irq
//  tmr_chipselect   out  1   Avalon chipselect to timer
//  tmr_address      out  3   0=fin_cuenta 1=threshold 2=control{borra_irq,enable} 3=count(RO)
//  tmr_write        out  1   1-cycle write strobe
//  tmr_writedata    out  32  write data
//  tmr_read         out  1   1-cycle read strobe
//  tmr_readdata     in   32  read data, valid RD_LAT cycles after tmr_read
//  busy             out  1   high from accepted start until DONE returns to IDLE
//  done             out  1   1-cycle pulse when the timer has been disabled
//  periods_done     out  PW  irqs serviced in current/last sequence
//  last_count       out  32  count captured at the most recent irq
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, no bus strobes. Reset mid-sequence: abandon at once, no disable write.
//  Each bus access is one cycle. chipselect is high only together with write or read.
//  FSM: IDLE -start-> WR_PER(a0=cfg_period) -> WR_THR(a1=cfg_threshold) -> WR_EN(a2=0x1)
//   -> RUN -irq & guard==0-> RD_CNT(read a3) -> RD_WAIT(RD_LAT cycles) -> ACK_SET(a2=0x3)
//   -> ACK_CLR(a2=0x1) -> RUN or STOP_WR -> DONE -> IDLE.
//  start: cfg_* are sampled into internal registers on the accepting cycle. Later cfg changes do
//   not affect the running sequence. periods_done clears to 0 on accept; last_count is held.
//  RD_WAIT: on its last cycle, last_count <= tmr_readdata.
//  ACK_CLR: periods_done += 1 (wraps at 2^PW-1 -> 0). Guard counter loads IRQ_GUARD.
//   Go to STOP_WR if num_periods!=0 and the new periods_done==num_periods; else go to RUN.
//  RUN: guard counts down to 0. irq is ignored while guard!=0.
//  STOP_WR: write a2=0x0 (disable). DONE: done=1 for one cycle, busy=1; busy falls in IDLE.
//  stop: latched if it arrives in any busy state other than RUN. The current single-cycle access
//   completes. The FSM then goes to STOP_WR instead of its next state. A pending irq service
//   (RD_CNT..ACK_CLR) finishes first and is counted.
//  stop and irq together in RUN: stop wins; irq not serviced or counted.
//  stop in IDLE: ignored. start while busy: ignored. start and stop together in IDLE: start accepted, stop ignored.
//  irq outside RUN: not acted on until RUN with guard==0 (level is held by the timer).
//  Start-to-enable latency: start at cycle 0 -> writes at 1,2,3 -> RUN at 4.
// TESTING
//  1 period=100,thr=40,N=3: writes a0=100,a1=40,a2=1 on 3 consecutive cycles; 3 irqs ->
//    periods_done=3, final write a2=0, done pulse exactly once, busy falls the cycle after done.
//  2 irq service: timer count=57 at read -> last_count=57; seq read a3, a2=3, a2=1;
//    irq still high 1 cycle after ACK_CLR -> not recounted (IRQ_GUARD=2).
//  3 N=0 free-run, 5 irqs then stop in RUN -> periods_done=5, a2=0 written, done pulse.
//  4 stop during WR_THR -> WR_THR write completes, next access a2=0, done; no a2=1 enable write.
//  5 stop and irq same cycle in RUN -> no read of a3, periods_done unchanged, a2=0 written.
//  6 reset asserted in RD_WAIT -> next cycle all outputs 0, IDLE; start accepted afterwards.

Source files
------------

// File: rtl/timer_sequencer.sv
// timer_sequencer: Avalon-MM master that configures the avalon_timer slave,
// services its irq (read live count, pulse borra_irq), counts periods and
// disables the timer after N periods or on stop.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start, no bus activity
// WR_PER  | write end-of-count (a0)
// WR_THR  | write threshold (a1)
// WR_EN   | write control enable (a2 = 0x1)
// RUN     | timer running, guard counts down, wait for irq or stop
// RD_CNT  | read live count (a3)
// RD_WAIT | wait for read data, capture on last cycle
// ACK_SET | write control {borra_irq,enable} (a2 = 0x3)
// ACK_CLR | write control enable only (a2 = 0x1), count the period
// STOP_WR | disable timer (a2 = 0x0)
// DONE    | one-cycle done pulse
module timer_sequencer #(
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned IRQ_GUARD = 2,
    parameter int unsigned PW        = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic [31:0]   cfg_period,
    input  logic [31:0]   cfg_threshold,
    input  logic [PW-1:0] cfg_num_periods,
    input  logic          timer_irq,
    output logic          tmr_chipselect,
    output logic [2:0]    tmr_address,
    output logic          tmr_write,
    output logic [31:0]   tmr_writedata,
    output logic          tmr_read,
    input  logic [31:0]   tmr_readdata,
    output logic          busy,
    output logic          done,
    output logic [PW-1:0] periods_done,
    output logic [31:0]   last_count
);

    localparam logic [7:0] RD_WAIT_INIT = 8'(RD_LAT - 1);
    localparam logic [7:0] GUARD_INIT   = 8'(IRQ_GUARD);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_WR_PER  = 4'd1,
        S_WR_THR  = 4'd2,
        S_WR_EN   = 4'd3,
        S_RUN     = 4'd4,
        S_RD_CNT  = 4'd5,
        S_RD_WAIT = 4'd6,
        S_ACK_SET = 4'd7,
        S_ACK_CLR = 4'd8,
        S_STOP_WR = 4'd9,
        S_DONE    = 4'd10
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   period_q, thr_q;
    logic [PW-1:0] num_q;
    logic [PW-1:0] periods_q;
    logic [PW-1:0] periods_inc;
    logic [31:0]   last_count_q;
    logic [7:0]    wait_q;
    logic [7:0]    guard_q;
    logic          stop_pend_q;
    logic          stop_req;
    logic          accept;

    assign accept      = (state_q == S_IDLE) && start;
    assign stop_req    = stop || stop_pend_q;
    assign periods_inc = periods_q + PW'(1);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; stop is honoured only between accesses, and an irq
    // service that has begun always runs to ACK_CLR before stopping.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (start) state_d = S_WR_PER;
            S_WR_PER:  state_d = stop_req ? S_STOP_WR : S_WR_THR;
            S_WR_THR:  state_d = stop_req ? S_STOP_WR : S_WR_EN;
            S_WR_EN:   state_d = stop_req ? S_STOP_WR : S_RUN;
            S_RUN: begin
                if (stop_req)                          state_d = S_STOP_WR;
                else if (timer_irq && guard_q == 8'd0) state_d = S_RD_CNT;
            end
            S_RD_CNT:  state_d = S_RD_WAIT;
            S_RD_WAIT: if (wait_q == 8'd0) state_d = S_ACK_SET;
            S_ACK_SET: state_d = S_ACK_CLR;
            S_ACK_CLR: begin
                if (stop_req || (num_q != '0 && periods_inc == num_q))
                    state_d = S_STOP_WR;
                else
                    state_d = S_RUN;
            end
            S_STOP_WR: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Bus strobes and status decoded from the current state.
    always_comb begin
        tmr_chipselect = 1'b0;
        tmr_address    = 3'd0;
        tmr_write      = 1'b0;
        tmr_writedata  = 32'd0;
        tmr_read       = 1'b0;
        unique case (state_q)
            S_WR_PER: begin
                tmr_chipselect = 1'b1; tmr_write = 1'b1;
                tmr_address = 3'd0; tmr_writedata = period_q;
            end
            S_WR_THR: begin
                tmr_chipselect = 1'b1; tmr_write = 1'b1;
                tmr_address = 3'd1; tmr_writedata = thr_q;
            end
            S_WR_EN, S_ACK_CLR: begin
                tmr_chipselect = 1'b1; tmr_write = 1'b1;
                tmr_address = 3'd2; tmr_writedata = 32'h1;
            end
            S_ACK_SET: begin
                tmr_chipselect = 1'b1; tmr_write = 1'b1;
                tmr_address = 3'd2; tmr_writedata = 32'h3;
            end
            S_STOP_WR: begin
                tmr_chipselect = 1'b1; tmr_write = 1'b1;
                tmr_address = 3'd2; tmr_writedata = 32'h0;
            end
            S_RD_CNT: begin
                tmr_chipselect = 1'b1; tmr_read = 1'b1;
                tmr_address = 3'd3;
            end
            default: ;
        endcase
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign periods_done = periods_q;
    assign last_count   = last_count_q;

    // Sequence datapath: config snapshot, period count, captured count,
    // read-latency and irq-guard down-counters, latched stop request.
    always_ff @(posedge clock) begin
        if (reset) begin
            period_q     <= '0;
            thr_q        <= '0;
            num_q        <= '0;
            periods_q    <= '0;
            last_count_q <= '0;
            wait_q       <= '0;
            guard_q      <= '0;
            stop_pend_q  <= 1'b0;
        end else begin
            if (accept) begin
                period_q  <= cfg_period;
                thr_q     <= cfg_threshold;
                num_q     <= cfg_num_periods;
                periods_q <= '0;
                guard_q   <= '0;
            end

            // RUN consumes stop directly, so only the other busy states latch it.
            if (state_q == S_DONE || accept)
                stop_pend_q <= 1'b0;
            else if (stop && state_q != S_IDLE && state_q != S_RUN)
                stop_pend_q <= 1'b1;

            if (state_q == S_RD_CNT)
                wait_q <= RD_WAIT_INIT;
            else if (state_q == S_RD_WAIT && wait_q != 8'd0)
                wait_q <= wait_q - 8'd1;

            if (state_q == S_RD_WAIT && wait_q == 8'd0)
                last_count_q <= tmr_readdata;

            if (state_q == S_ACK_CLR) begin
                periods_q <= periods_inc;
                guard_q   <= GUARD_INIT;
            end else if (state_q == S_RUN && guard_q != 8'd0) begin
                guard_q <= guard_q - 8'd1;
            end
        end
    end

endmodule
